// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if
// Request-side bus of the serial transmit arbiter. It bundles NREQ
// byte producers, each with its own valid/ready handshake.
//   req_valid : bit i set when requester i has a byte to send
//   req_data  : byte i is req_data[8*i+7:8*i]
//   req_ready : one-hot or zero; bit i set when byte i is taken on this edge
// The master modport is the producers' side. The slave modport is the arbiter's side.
interface serial_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares a single serial transmit line between NREQ byte producers.
// A round-robin arbiter picks the producer whose byte is sent next.
// Each byte is sent as one frame: a start bit (0), then 8 data bits
// LSB first, then a stop bit (1), then GAP idle bits (1). One bit is
// sent per clock.
// Ports:
//   clk        : single clock
//   resetn     : asynchronous reset, active low
//   bus        : request handshake bus (slave modport)
//   out        : serial line; the idle level is 1
//   busy       : a frame is in progress (start bit through last gap bit)
//   grant_id   : requester whose frame is current or was sent last
//   frame_done : one-cycle pulse during the stop-bit cycle
module serial_tx_arbiter #(
    parameter int  NREQ = 4,
    parameter int  GAP  = 0,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    serial_tx_arbiter_if.slave  bus,
    output logic                out,
    output logic                busy,
    output logic [IDW-1:0]      grant_id,
    output logic                frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    localparam logic [IDW-1:0] PTR_RST    = IDW'(NREQ - 1);
    localparam int             GAP_LAST_I = (GAP > 0) ? GAP - 1 : 0;
    localparam logic [3:0]     GAP_LAST   = GAP_LAST_I[3:0];

    state_t         state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [3:0]     gap_cnt, gap_cnt_n;
    logic [7:0]     shift, shift_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] grant_n;
    logic           out_n, busy_n, frame_done_n;

    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic           in_window;
    logic           accept;

    // Round-robin search. The search starts one slot after the last
    // winner and wraps around, so the most recently served requester
    // has the lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // The accept window is the idle state or the final bit-cycle of a
    // frame. Accepting in the final cycle lets the next start bit
    // follow the frame with no idle cycle in between.
    always_comb begin
        in_window = 1'b0;
        case (state)
            S_IDLE:  in_window = 1'b1;
            S_STOP:  in_window = (GAP == 0);
            S_GAP:   in_window = (gap_cnt == GAP_LAST);
            default: in_window = 1'b0;
        endcase
    end

    // Ready is combinational. It is held low while reset is asserted,
    // so nothing looks accepted during reset.
    always_comb begin
        accept        = resetn && in_window && found;
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic. The output values are computed from the next
    // state, so the registered outputs line up with the phase they describe.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        grant_n   = grant_id;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                state_n   = S_DATA;
                bit_cnt_n = 3'd0;
            end
            S_DATA: begin
                shift_n = {1'b0, shift[7:1]};
                if (bit_cnt == 3'd7) begin
                    state_n = S_STOP;
                end else begin
                    bit_cnt_n = bit_cnt + 3'd1;
                end
            end
            S_STOP: begin
                if (accept) begin
                    state_n = S_START;
                end else if (GAP == 0) begin
                    state_n = S_IDLE;
                end else begin
                    state_n   = S_GAP;
                    gap_cnt_n = 4'd0;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = accept ? S_START : S_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (accept) begin
            shift_n = bus.req_data[8*winner +: 8];
            ptr_n   = winner;
            grant_n = winner;
        end

        case (state_n)
            S_START: out_n = 1'b0;
            S_DATA:  out_n = shift_n[0];
            default: out_n = 1'b1;
        endcase
        busy_n       = (state_n != S_IDLE);
        frame_done_n = (state_n == S_STOP);
    end

    // State and output registers. Reset takes effect at once and cuts
    // off any frame in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            gap_cnt    <= 4'd0;
            shift      <= 8'd0;
            ptr        <= PTR_RST;
            grant_id   <= '0;
            out        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            shift      <= shift_n;
            ptr        <= ptr_n;
            grant_id   <= grant_n;
            out        <= out_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Shares one serial transmit line between `NREQ` byte producers. It accepts bytes over per-requester valid/ready handshakes and picks a winner by round-robin. Each byte goes out as a frame: one start bit (0), 8 data bits LSB first, one stop bit (1), then optional idle gap bits (1). This is the transmit counterpart of the team's serial byte receiver FSM, which uses the same framing and a 1 idle level, and the block feeds that receiver's `in` line directly.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `GAP`, default 0: extra idle (1) bit-cycles inserted after each stop bit, 0..15.
- `clk`  in  1  single clock; one bit is sent per cycle.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i has a byte to send.
- `req_data`  in  8*NREQ  byte i is `req_data[8*i+7:8*i]`.
- `req_ready`  out  NREQ  one-hot or zero; bit i means byte i is accepted on this edge.
- `out`  out  1  serial line; idle level is 1.
- `busy`  out  1  a frame is in progress (start bit through last gap bit).
- `grant_id`  out  max(1,$clog2(NREQ))  index of the requester whose frame is current or last sent.
- `frame_done`  out  1  one-cycle pulse during the stop-bit cycle.

## Operation
- FSM states:
  - IDLE: `out`=1.
  - START: `out`=0.
  - DATA: 8 cycles, 3-bit counter, `out`=shift[0], shift right.
  - STOP: `out`=1, `frame_done`=1.
  - GAP: `GAP` cycles, `out`=1; skipped when `GAP`=0.
- Accept window:
  - IDLE, or the final cycle of a frame: STOP when `GAP`=0, otherwise the last GAP cycle.
  - Only inside the window, `req_ready[w]`=1 for the winner w among the asserted `req_valid`. `req_ready` is combinational from `req_valid`, the state and the pointer.
- Transfer: on an edge where `req_valid[w]` & `req_ready[w]` are both set:
  - the byte is latched into the shift register;
  - `grant_id`<=w and pointer<=w;
  - next state is START.
- If no transfer happens in the window, the next state is IDLE.
- Round-robin:
  - Search starts at (pointer+1) mod NREQ and wraps around.
  - Reset pointer = NREQ-1, so requester 0 wins first.
  - The pointer updates only on a transfer.
- Requester rules:
  - Hold `req_data` stable while valid is set and not yet accepted.
  - Dropping valid before acceptance is legal; the byte is then simply not sent.
  - The arbiter never accepts in a cycle where valid=0.
- `busy`=1 in START, DATA, STOP and GAP; 0 in IDLE.
- Requests that arrive mid-frame are not accepted and not lost. The requester keeps valid asserted, and arbitration happens in the next window.
- All outputs except `req_ready` are registered.

## Timing
- Reset (`resetn`=0, takes effect immediately, asynchronous) drives:
  - state=IDLE, `out`=1, `busy`=0, `frame_done`=0, `grant_id`=0, `req_ready`=0, pointer=NREQ-1, counters 0.
- Reset mid-frame truncates the frame: `out` goes to 1 at once, and no `frame_done` is produced.
- Latency: if the accept edge is T, the start bit is on `out` in cycle T+1, data bit k in cycle T+2+k, and the stop bit in cycle T+10.
- Frame length is 10+GAP cycles.
- Back-to-back frames with no idle cycle between them are sustained when a valid is pending in the accept window. Throughput is 1 byte per 10+GAP cycles.
- Simultaneous valid on several requesters: exactly one is accepted per window, chosen by round-robin order.
- Only one requester: it is granted every window; no starvation logic is needed.
- `frame_done` rises in the cycle after the bit-7 cycle and lasts exactly 1 cycle.

## Test plan
- Single byte, NREQ=4, GAP=0:
  - Stimulus: `req_valid`=4'b0010, data1=8'hA5, accept at edge T.
  - Response: `out` from T+1 is 0,1,0,1,0,0,1,0,1,1, then 1 idle.
  - `grant_id`=1, `frame_done` high only in the stop cycle, and the ready pulse is exactly 1 cycle.
- Round-robin: all four valid held continuously, data = 8'h10+i.
  - Grant order is 0,1,2,3,0.
  - Frames are back-to-back, 10 cycles each, with no idle bit between stop and next start.
- GAP=3: two frames from requester 2.
  - Exactly 3 idle 1-cycles after each stop bit.
  - The second ready occurs in the last gap cycle; the period is 13 cycles.
- Mid-frame request: requester 3 raises valid during DATA of requester 0's frame.
  - No `req_ready[3]` until the stop cycle.
  - Then requester 3 is accepted, and its start bit immediately follows the stop bit.
- Withdrawn request: requester 1 valid for 2 cycles during a busy frame, then dropped before the window.
  - No grant to requester 1; the line returns to IDLE with `out`=1 and `busy`=0.
- Asynchronous reset during data bit 4:
  - `out`=1, `busy`=0, no `frame_done` pulse.
  - After release, requester 0 wins over a simultaneous request from requester 2.
- Loopback check: `out` wired into the serial receiver FSM.
  - 50 random bytes from random requesters are received in order with correct values.
